// File: rtl/time_keeper.sv
// +----------------------------------------------------------------------+
// | time_keeper                                                          |
// | HH:MM:SS up-clock / countdown timer with debounced edit keys and a   |
// | 6-digit multiplexed 7-segment driver.                                |
// | Optional: define TIME_KEEPER_BLINK_EN to blink the edited field.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module time_keeper #(
  parameter int TICK_DIV        = 100000000,
  parameter int SCAN_DIV        = 20000,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_CYCLES   = 30000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_state,
  input  logic       run_mode,
  input  logic       set_mode,
  input  logic [1:0] set_sel,
  input  logic       inc_key,
  input  logic       dec_key,
  output logic [7:0] tub_segments_1,
  output logic [7:0] tub_segments_2,
  output logic [5:0] tub_select,
  output logic       expired,
  output logic       expire_pulse
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_HIT   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_DONE  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic [4:0]        hours;
  logic [5:0]        minutes;
  logic [5:0]        seconds;
  logic [TICK_W-1:0] tick_cnt;
  logic              run_mode_q;
  logic [DEB_W-1:0]  inc_db, dec_db;
  logic [REP_W-1:0]  inc_rp, dec_rp;
  logic              key_lock;
  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        scan_idx;

  logic tick, mode_change, last_second, time_zero;
  logic inc_level, dec_level, both_keys, inc_step, dec_step, edit_en, do_inc, do_dec;
  logic [3:0] digit;
  logic       blank;
  logic [7:0] digit_code;
  logic [7:0] hr_bcd, mn_bcd, sc_bcd;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 8'hFC;
      4'd1: return 8'h60;
      4'd2: return 8'hDA;
      4'd3: return 8'hF2;
      4'd4: return 8'h66;
      4'd5: return 8'hB6;
      4'd6: return 8'hBE;
      4'd7: return 8'hE0;
      4'd8: return 8'hFE;
      4'd9: return 8'hE6;
      default: return 8'h00;
    endcase
  endfunction

  // Tick qualification and key acceptance decode
  always_comb begin
    mode_change = (run_mode != run_mode_q);
    tick        = !set_mode && !mode_change && (tick_cnt == TICK_LAST);
    time_zero   = (hours == 5'd0) && (minutes == 6'd0) && (seconds == 6'd0);
    last_second = (hours == 5'd0) && (minutes == 6'd0) && (seconds == 6'd1);
    // A key's debounced level includes the cycle in which it first qualifies
    inc_level   = inc_key && (inc_db >= DEB_HIT);
    dec_level   = dec_key && (dec_db >= DEB_HIT);
    both_keys   = inc_level && dec_level;
    inc_step    = inc_key && ((inc_db == DEB_HIT) || ((inc_db == DEB_DONE) && (inc_rp == REP_LAST)));
    dec_step    = dec_key && ((dec_db == DEB_HIT) || ((dec_db == DEB_DONE) && (dec_rp == REP_LAST)));
    edit_en     = set_mode && (set_sel != 2'd3);
    do_inc      = edit_en && !both_keys && !key_lock && inc_step;
    do_dec      = edit_en && !both_keys && !key_lock && dec_step;
  end

  // Increment key debounce and hold-to-repeat counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_db <= '0;
      inc_rp <= '0;
    end else if (!power_state || !inc_key) begin
      inc_db <= '0;
      inc_rp <= '0;
    end else if (inc_db != DEB_DONE) begin
      inc_db <= inc_db + DEB_W'(1);
    end else begin
      inc_rp <= (inc_rp == REP_LAST) ? '0 : inc_rp + REP_W'(1);
    end
  end

  // Decrement key debounce and hold-to-repeat counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_db <= '0;
      dec_rp <= '0;
    end else if (!power_state || !dec_key) begin
      dec_db <= '0;
      dec_rp <= '0;
    end else if (dec_db != DEB_DONE) begin
      dec_db <= dec_db + DEB_W'(1);
    end else begin
      dec_rp <= (dec_rp == REP_LAST) ? '0 : dec_rp + REP_W'(1);
    end
  end

  // Chord lockout: set when both keys qualify together, cleared once both are released
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              key_lock <= 1'b0;
    else if (!power_state)                   key_lock <= 1'b0;
    else if (!inc_key && !dec_key)           key_lock <= 1'b0;
    else if (both_keys)                      key_lock <= 1'b1;
  end

  // Tick divider, run-mode tracking and expiry flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt     <= '0;
      run_mode_q   <= 1'b0;
      expired      <= 1'b0;
      expire_pulse <= 1'b0;
    end else begin
      run_mode_q   <= run_mode;
      expire_pulse <= 1'b0;
      if (!power_state || mode_change || set_mode) begin
        tick_cnt <= '0;
        expired  <= 1'b0;
      end else if (tick) begin
        tick_cnt <= '0;
        if (run_mode && last_second) begin
          expired      <= 1'b1;
          expire_pulse <= 1'b1;
        end
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  // Time register: field edits in set mode, carry/borrow counting on ticks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || !power_state) begin
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
    end else if (set_mode) begin
      if (do_inc || do_dec) begin
        case (set_sel)
          2'd0: seconds <= do_inc ? wrap_inc(seconds, 6'd59) : wrap_dec(seconds, 6'd59);
          2'd1: minutes <= do_inc ? wrap_inc(minutes, 6'd59) : wrap_dec(minutes, 6'd59);
          2'd2: hours   <= 5'(do_inc ? wrap_inc({1'b0, hours}, 6'd23) : wrap_dec({1'b0, hours}, 6'd23));
          default: ;
        endcase
      end
    end else if (tick) begin
      if (!run_mode) begin
        seconds <= wrap_inc(seconds, 6'd59);
        if (seconds == 6'd59) begin
          minutes <= wrap_inc(minutes, 6'd59);
          if (minutes == 6'd59) hours <= 5'(wrap_inc({1'b0, hours}, 6'd23));
        end
      end else if (!time_zero) begin
        seconds <= wrap_dec(seconds, 6'd59);
        if (seconds == 6'd0) begin
          minutes <= wrap_dec(minutes, 6'd59);
          if (minutes == 6'd0) hours <= hours - 5'd1;
        end
      end
    end
  end

`ifdef TIME_KEEPER_BLINK_EN
  logic [TICK_W-1:0] blink_cnt;
  logic [1:0]        idx_field;

  // Blink phase keeps running in set mode, unlike the tick divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   blink_cnt <= '0;
    else if (!power_state || blink_cnt == TICK_LAST) blink_cnt <= '0;
    else                                          blink_cnt <= blink_cnt + TICK_W'(1);
  end

  // Blank the selected field's digits during the second half of the period
  always_comb begin
    idx_field = (scan_idx < 3'd2) ? 2'd2 : (scan_idx < 3'd4) ? 2'd1 : 2'd0;
    blank     = set_mode && (set_sel != 2'd3) && (set_sel == idx_field) &&
                (blink_cnt >= TICK_W'(TICK_DIV / 2));
  end
`else
  // No blanking in the default build
  always_comb blank = 1'b0;
`endif

  // Digit value and segment code for the slot about to be shown
  always_comb begin
    hr_bcd = to_bcd({1'b0, hours});
    mn_bcd = to_bcd(minutes);
    sc_bcd = to_bcd(seconds);
    case (scan_idx)
      3'd0:    digit = hr_bcd[7:4];
      3'd1:    digit = hr_bcd[3:0];
      3'd2:    digit = mn_bcd[7:4];
      3'd3:    digit = mn_bcd[3:0];
      3'd4:    digit = sc_bcd[7:4];
      default: digit = sc_bcd[3:0];
    endcase
    digit_code = blank ? 8'h00 : seg_of(digit);
  end

  // Scan counter and registered tube outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || !power_state) begin
      scan_cnt       <= '0;
      scan_idx       <= '0;
      tub_select     <= '0;
      tub_segments_1 <= '0;
      tub_segments_2 <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt       <= '0;
      scan_idx       <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
      tub_select     <= 6'b100000 >> scan_idx;
      tub_segments_1 <= (scan_idx < 3'd4) ? digit_code : 8'h00;
      tub_segments_2 <= (scan_idx < 3'd4) ? 8'h00 : digit_code;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

endmodule

`default_nettype wire
